// File: rtl/exe_pkg.sv
// Shared definitions for the MIPS execute stage: ALU codes, forwarding and
// HI/LO-read encodings, the multiply/divide FSM states and iteration count.
package exe_pkg;

  localparam int MULDIV_CYCLES = 32;
  localparam int CNT_W         = $clog2(MULDIV_CYCLES);

  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_SUB   = 4'd1;
  localparam logic [3:0] ALU_AND   = 4'd2;
  localparam logic [3:0] ALU_OR    = 4'd3;
  localparam logic [3:0] ALU_XOR   = 4'd4;
  localparam logic [3:0] ALU_NOR   = 4'd5;
  localparam logic [3:0] ALU_SLT   = 4'd6;
  localparam logic [3:0] ALU_SLTU  = 4'd7;
  localparam logic [3:0] ALU_SLL   = 4'd8;
  localparam logic [3:0] ALU_SRL   = 4'd9;
  localparam logic [3:0] ALU_SRA   = 4'd10;
  localparam logic [3:0] ALU_LUI   = 4'd11;
  localparam logic [3:0] ALU_MULT  = 4'd12;
  localparam logic [3:0] ALU_MULTU = 4'd13;
  localparam logic [3:0] ALU_DIV   = 4'd14;
  localparam logic [3:0] ALU_DIVU  = 4'd15;

  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

  localparam logic [1:0] MF_HI = 2'b01;
  localparam logic [1:0] MF_LO = 2'b10;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_BUSY = 2'd1,
    MD_DONE = 2'd2
  } md_state_e;

  // Codes 00 and 11 both select the register-file value.
  function automatic logic [31:0] fwd_pick(input logic [1:0]  sel,
                                           input logic [31:0] reg_val,
                                           input logic [31:0] mem_val,
                                           input logic [31:0] wb_val);
    logic [31:0] r;
    r = reg_val;
    if (sel == FWD_MEM) r = mem_val;
    else if (sel == FWD_WB) r = wb_val;
    return r;
  endfunction

endpackage

// File: rtl/muldiv_seq.sv
// 32-iteration shift/add multiplier and restoring divider owning HI/LO.
// The divider datapath is only built when MULDIV_DIV_EN is defined.
module muldiv_seq
  import exe_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        stall,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MULDIV_CYCLES - 1);

  md_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      acc_q, acc_d;   // upper product half / partial remainder
  logic [31:0]      low_q, low_d;   // multiplier, or dividend turning into quotient
  logic [31:0]      opb_q, opb_d;
  logic             is_div_q, is_div_d;
  logic             neg_res_q, neg_res_d;
  logic             neg_rem_q, neg_rem_d;
  logic             div0_q, div0_d;
  logic [31:0]      dvd_q, dvd_d;
  logic [31:0]      hi_q, hi_d;
  logic [31:0]      lo_q, lo_d;

  logic        start_ok;
  logic        sign_a, sign_b;
  logic [31:0] mag_a, mag_b;
  logic [32:0] mul_sum;
  logic [31:0] step_acc, step_low;
  logic [63:0] prod;
  logic [31:0] res_hi, res_lo;

  always_comb begin
    sign_a = ~op[0] & a[31];
    sign_b = ~op[0] & b[31];
    mag_a  = sign_a ? (~a + 32'd1) : a;
    mag_b  = sign_b ? (~b + 32'd1) : b;
`ifdef MULDIV_DIV_EN
    start_ok = start;
`else
    start_ok = start & ~op[1];
`endif
  end

  // One iteration of the datapath, plus the sign-corrected result it would give.
  always_comb begin
    mul_sum  = {1'b0, acc_q} + (low_q[0] ? {1'b0, opb_q} : 33'd0);
    step_acc = mul_sum[32:1];
    step_low = {mul_sum[0], low_q[31:1]};
    prod     = {step_acc, step_low};
    if (neg_res_q) prod = ~prod + 64'd1;
    res_hi = prod[63:32];
    res_lo = prod[31:0];
`ifdef MULDIV_DIV_EN
    if (is_div_q) begin
      if ({acc_q, low_q[31]} >= {1'b0, opb_q}) begin
        step_acc = 32'({acc_q, low_q[31]} - {1'b0, opb_q});
        step_low = {low_q[30:0], 1'b1};
      end else begin
        step_acc = {acc_q[30:0], low_q[31]};
        step_low = {low_q[30:0], 1'b0};
      end
      res_lo = neg_res_q ? (~step_low + 32'd1) : step_low;
      res_hi = neg_rem_q ? (~step_acc + 32'd1) : step_acc;
      if (div0_q) begin
        res_hi = dvd_q;
        res_lo = '1;
      end
    end
`endif
  end

`ifndef MULDIV_DIV_EN
  logic unused_div;
  assign unused_div = ^{is_div_q, neg_rem_q, div0_q, dvd_q};
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    low_d     = low_q;
    opb_d     = opb_q;
    is_div_d  = is_div_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    div0_d    = div0_q;
    dvd_d     = dvd_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    stall     = 1'b0;
    case (state_q)
      MD_IDLE: begin
        if (start_ok) begin
          stall     = 1'b1;
          state_d   = MD_BUSY;
          cnt_d     = '0;
          acc_d     = '0;
          low_d     = mag_a;
          opb_d     = mag_b;
          is_div_d  = op[1];
          neg_res_d = sign_a ^ sign_b;
          neg_rem_d = sign_a;
          div0_d    = (b == 32'd0);
          dvd_d     = a;
        end
      end
      MD_BUSY: begin
        stall = 1'b1;
        acc_d = step_acc;
        low_d = step_low;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          hi_d    = res_hi;
          lo_d    = res_lo;
          state_d = MD_DONE;
        end
      end
      // The held instruction still presents its opcode here; it must not restart.
      MD_DONE: state_d = MD_IDLE;
      default: state_d = MD_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= MD_IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      low_q     <= '0;
      opb_q     <= '0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      div0_q    <= 1'b0;
      dvd_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      low_q     <= low_d;
      opb_q     <= opb_d;
      is_div_q  <= is_div_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      div0_q    <= div0_d;
      dvd_q     <= dvd_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  assign hi = hi_q;
  assign lo = lo_q;

endmodule

// File: rtl/exe_stage.sv
// MIPS execute stage: operand forwarding, single-cycle ALU, destination mux and
// the sequential mul/div unit. Define MULDIV_DIV_EN to build DIV/DIVU support.
module exe_stage
  import exe_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [4:0]  exe_signal,
  input  logic        reg_dst,
  input  logic [1:0]  mf_sel,
  input  logic [5:0]  opcode,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [31:0] datareg1,
  input  logic [31:0] datareg2,
  input  logic [31:0] output_val,
  input  logic [1:0]  fwd_a_sel,
  input  logic [1:0]  fwd_b_sel,
  input  logic [31:0] mem_alu_result,
  input  logic [31:0] wb_data,
  output logic [31:0] alu_result,
  output logic [31:0] write_data,
  output logic [4:0]  dest_reg,
  output logic        stall,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  logic        alu_src;
  logic [3:0]  alu_ctrl;
  logic [31:0] op_a, op_b_reg, op_b;
  logic [4:0]  shamt;
  logic [31:0] alu_out;
  logic        md_start;
  logic [31:0] md_hi, md_lo;

  assign alu_src  = exe_signal[4];
  assign alu_ctrl = exe_signal[3:0];
  assign shamt    = output_val[10:6];

  always_comb begin
    op_a     = fwd_pick(fwd_a_sel, datareg1, mem_alu_result, wb_data);
    op_b_reg = fwd_pick(fwd_b_sel, datareg2, mem_alu_result, wb_data);
    op_b     = alu_src ? output_val : op_b_reg;
  end

  always_comb begin
    alu_out = '0;
    case (alu_ctrl)
      ALU_ADD:  alu_out = op_a + op_b;
      ALU_SUB:  alu_out = op_a - op_b;
      ALU_AND:  alu_out = op_a & op_b;
      ALU_OR:   alu_out = op_a | op_b;
      ALU_XOR:  alu_out = op_a ^ op_b;
      ALU_NOR:  alu_out = ~(op_a | op_b);
      ALU_SLT:  alu_out = {31'd0, ($signed(op_a) < $signed(op_b))};
      ALU_SLTU: alu_out = {31'd0, (op_a < op_b)};
      ALU_SLL:  alu_out = op_b << shamt;
      ALU_SRL:  alu_out = op_b >> shamt;
      ALU_SRA:  alu_out = $signed(op_b) >>> shamt;
      ALU_LUI:  alu_out = op_b << 16;
      ALU_MULT, ALU_MULTU, ALU_DIV, ALU_DIVU: alu_out = '0;
      default:  alu_out = '0;
    endcase
  end

  // HI/LO reads take priority over whatever the ALU computes.
  always_comb begin
    alu_result = alu_out;
    if (mf_sel == MF_HI) alu_result = md_hi;
    else if (mf_sel == MF_LO) alu_result = md_lo;
  end

  assign write_data = op_b_reg;
  assign dest_reg   = reg_dst ? rd : rt;
  assign md_start   = in_valid & (alu_ctrl[3:2] == 2'b11);

  muldiv_seq u_muldiv (
    .clk   (clk),
    .rst   (rst),
    .start (md_start),
    .op    (alu_ctrl[1:0]),
    .a     (op_a),
    .b     (op_b_reg),
    .stall (stall),
    .hi    (md_hi),
    .lo    (md_lo)
  );

  assign hi = md_hi;
  assign lo = md_lo;

  logic unused_inputs;
  assign unused_inputs = ^{opcode, rs};

endmodule
